// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract controller time-sharing one 1-bit full adder, LSB first.
// Latency WIDTH cycles from accept to out_valid; DONE holds its result until out_ready.

module FullAdder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] r_q,         r_d;
    logic             c_q,         c_d;
    logic             c_msb_q,     c_msb_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q,  overflow_d;

    logic fa_sum;
    logic fa_carry;

    FullAdder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        r_d         = r_q;
        c_d         = c_q;
        c_msb_d     = c_msb_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B here, the +1 enters as the initial carry.
                    a_sh_d  = a;
                    b_sh_d  = b ^ {WIDTH{sub}};
                    c_d     = sub;
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                r_d    = {fa_sum, r_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = fa_carry;
                cnt_d  = cnt_q + CW'(1);
                // The adder carry out of bit WIDTH-2 is the carry into the MSB.
                if (cnt_q == CNT_MSB_IN) begin
                    c_msb_d = fa_carry;
                end
                if (cnt_q == CNT_LAST) begin
                    sum_d       = r_d;
                    carry_out_d = fa_carry;
                    overflow_d  = c_msb_q ^ fa_carry;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_q         <= '0;
            c_q         <= 1'b0;
            c_msb_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            r_q         <= r_d;
            c_q         <= c_d;
            c_msb_q     <= c_msb_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl (WIDTH=16) against an arithmetic reference model.
module tb_serial_add_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        int ux, uy, sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            es = W'(ux - uy);
            ec = (ux >= uy);
            sr = sx - sy;
        end else begin
            es = W'(ux + uy);
            ec = (ux + uy) > 65535;
            sr = sx + sy;
        end
        eo = (sr > 32767) || (sr < -32768);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input int stall);
        logic [W-1:0] es;
        logic ec, eo;
        int lat, busy, unstable;
        model(x, y, s, es, ec, eo);
        chk("ready_before_op", in_ready, 1);
        a = x; b = y; sub = s; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = $urandom_range(0, 1);
        lat = 0; busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, W);
        chk("ready_low_cycles", busy, W);
        chk("sum", sum, es);
        chk("carry_out", carry_out, ec);
        chk("overflow", overflow, eo);
        if (stall > 0) begin
            unstable = 0;
            for (int i = 0; i < stall; i++) begin
                in_valid = (i == 3);
                @(negedge clk);
                if (!out_valid || in_ready || sum !== es || carry_out !== ec || overflow !== eo)
                    unstable++;
            end
            in_valid = 1'b0;
            chk("stall_stable", unstable, 0);
            out_ready = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk("ready_after_hs", in_ready, 1);
        chk("valid_after_hs", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h0003, 16'h0005, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h0005, 16'h0003, 1'b1, 0);
        do_op(16'h0003, 16'h0005, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 0);
        do_op(16'h1357, 16'h2468, 1'b0, 10);
        @(negedge clk);
        chk("no_accept_from_stall_pulse", in_ready, 1);

        // Reset during RUN once the bit counter has reached 7.
        a = 16'hABCD; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_rst_ready", in_ready, 1);
        chk("midrun_rst_valid", out_valid, 0);
        chk("midrun_rst_sum", sum, 0);
        do_op(16'h1234, 16'h1111, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                  (i % 6 == 5) ? int'($urandom_range(4, 8)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
